seg_scan_decoder: RTL

Receive-side counterpart of the two-digit hex seven-segment driver: samples a time-multiplexed seven-segment bus (segment lines plus digit-select lines), waits for each digit's pattern to settle, decodes patterns back to nibbles and reassembles the 8-bit value. It sits at the loopback/verification end of the display path, where it checks or recovers what the display driver is showing, and it flags any pattern that is not a legal hex glyph.

---
 rtl/seg_pkg.sv | 46 ++++
 rtl/seg_scan_decoder_if.sv | 11 +
 rtl/seg_pattern_decode.sv | 40 ++++
 rtl/seg_scan_decoder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: glyph patterns, segment bit positions,
// digit-select encodings and the receive-side frame state.
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    localparam int unsigned SEG_IDX_A  = 0;
    localparam int unsigned SEG_IDX_B  = 1;
    localparam int unsigned SEG_IDX_C  = 2;
    localparam int unsigned SEG_IDX_D  = 3;
    localparam int unsigned SEG_IDX_E  = 4;
    localparam int unsigned SEG_IDX_F  = 5;
    localparam int unsigned SEG_IDX_G  = 6;
    localparam int unsigned SEG_IDX_DP = 7;

    localparam logic [1:0] DIG1 = 2'b01;
    localparam logic [1:0] DIG2 = 2'b10;

    // One sample of the multiplexed display bus.
    typedef struct packed {
        logic [1:0] dig_sel;
        logic [7:0] seg;
    } seg_bus_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_GOT1  = 2'd1,
        ST_GOT2  = 2'd2
    } frame_state_t;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Display bus plus recovered-byte outputs of the seven-segment scan decoder.
interface seg_scan_decoder_if;
    logic [7:0] seg;
    logic [1:0] dig_sel;
    logic [7:0] value;
    logic       valid;
    logic       error;

    modport master (output seg, dig_sel, input value, valid, error);
    modport slave  (input seg, dig_sel, output value, valid, error);
endinterface

// File: rtl/seg_pattern_decode.sv
// Maps a seven-segment pattern back to its hex nibble; dp is ignored.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [7:0] seg,
    output logic [3:0] nibble,
    output logic       invalid
);

    logic [6:0] glyph_c;
    logic       dp_unused_c;

    assign glyph_c     = seg[SEG_IDX_G:SEG_IDX_A];
    assign dp_unused_c = seg[SEG_IDX_DP];

    always_comb begin
        nibble  = 4'h0;
        invalid = 1'b0;
        case (glyph_c)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the byte shown on a two-digit multiplexed seven-segment display:
// synchronize, wait for a stable digit, decode, and pair the two digits.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_decoder_if.slave  bus
);

    localparam int unsigned     CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 1);

    seg_bus_t         sync_q;
    seg_bus_t         s_q;
    seg_bus_t         prev_q;
    logic [CNT_W-1:0] cnt_q;

    frame_state_t state_q;
    frame_state_t state_nxt;

    logic [3:0] dig1_nib_q;
    logic       dig1_inv_q;
    logic [3:0] dig2_nib_q;
    logic       dig2_inv_q;

    logic [7:0] value_q;
    logic       valid_q;
    logic       error_q;

    logic [3:0] dec_nib_c;
    logic       dec_inv_c;
    logic       capture_c;
    logic       cap1_c;
    logic       cap2_c;
    logic       done_c;
    logic [7:0] frame_value_c;
    logic       frame_err_c;

    // Two-flop synchronizer, previous-sample register and saturating stability count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_q    <= '0;
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= '{dig_sel: bus.dig_sel, seg: bus.seg};
            s_q    <= sync_q;
            prev_q <= s_q;
            if (s_q != prev_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Fires only on the step into saturation, so a held pattern is taken once.
    assign capture_c = (s_q == prev_q) && (cnt_q == CNT_ARM);
    assign cap1_c    = capture_c && (s_q.dig_sel == DIG1);
    assign cap2_c    = capture_c && (s_q.dig_sel == DIG2);

    seg_pattern_decode u_decode (
        .seg     (s_q.seg),
        .nibble  (dec_nib_c),
        .invalid (dec_inv_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Frame assembly; the completing digit comes straight from the decoder.
    always_comb begin
        state_nxt     = state_q;
        done_c        = 1'b0;
        frame_value_c = {dig2_nib_q, dig1_nib_q};
        frame_err_c   = dig2_inv_q | dig1_inv_q;
        case (state_q)
            ST_EMPTY: begin
                if (cap1_c) begin
                    state_nxt = ST_GOT1;
                end else if (cap2_c) begin
                    state_nxt = ST_GOT2;
                end
            end
            ST_GOT1: begin
                if (cap2_c) begin
                    state_nxt     = ST_EMPTY;
                    done_c        = 1'b1;
                    frame_value_c = {dec_nib_c, dig1_nib_q};
                    frame_err_c   = dec_inv_c | dig1_inv_q;
                end
            end
            ST_GOT2: begin
                if (cap1_c) begin
                    state_nxt     = ST_EMPTY;
                    done_c        = 1'b1;
                    frame_value_c = {dig2_nib_q, dec_nib_c};
                    frame_err_c   = dig2_inv_q | dec_inv_c;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig1_nib_q <= '0;
            dig1_inv_q <= 1'b0;
            dig2_nib_q <= '0;
            dig2_inv_q <= 1'b0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            if (cap1_c) begin
                dig1_nib_q <= dec_nib_c;
                dig1_inv_q <= dec_inv_c;
            end
            if (cap2_c) begin
                dig2_nib_q <= dec_nib_c;
                dig2_inv_q <= dec_inv_c;
            end
            valid_q <= done_c;
            error_q <= done_c & frame_err_c;
            if (done_c) begin
                value_q <= frame_value_c;
            end
        end
    end

    assign bus.value = value_q;
    assign bus.valid = valid_q;
    assign bus.error = error_q;

endmodule
